// File: rtl/enemy_attack_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : enemy_attack_scheduler
//  Purpose  : Picks which formation ship leaves to dive at the player. One
//             launch attempt every ATTACK_INTERVAL frames, round-robin slot
//             choice, at most MAX_ACTIVE ships diving at once.
//  Revision : 1.0  initial release
// ============================================================================
module enemy_attack_scheduler #(
    parameter int NUM_SLOTS       = 18,
    parameter int MAX_ACTIVE      = 2,
    parameter int ATTACK_INTERVAL = 90
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic                 play,
    input  logic                 done,
    input  logic [NUM_SLOTS-1:0] alive,
    input  logic [NUM_SLOTS-1:0] dive_ack,
    input  logic [NUM_SLOTS-1:0] dive_done,
    output logic [NUM_SLOTS-1:0] dive_req,
    output logic [NUM_SLOTS-1:0] attacking,
    output logic [1:0]           active_cnt,
    output logic                 busy
);

    // ------------------------------------------------------------------------
    // Derived widths and constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int c_POP_W   = $clog2(NUM_SLOTS + 1);
    localparam int c_TIMER_W = (ATTACK_INTERVAL > 1) ? $clog2(ATTACK_INTERVAL) : 1;

    localparam logic [c_TIMER_W-1:0] c_RELOAD   = c_TIMER_W'(ATTACK_INTERVAL - 1);
    localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(NUM_SLOTS - 1);
    localparam logic [c_POP_W-1:0]   c_MAX_ACT  = c_POP_W'(MAX_ACTIVE);
    localparam logic [NUM_SLOTS-1:0] c_ONE      = NUM_SLOTS'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_SELECT  = 2'd2,
        S_REQUEST = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [c_IDX_W-1:0]     r_rr_ptr;
    logic [c_IDX_W-1:0]     r_scan_idx;
    logic [c_IDX_W-1:0]     r_scan_cnt;
    logic [c_IDX_W-1:0]     r_sel;
    logic [NUM_SLOTS-1:0]   r_dive_req;
    logic [NUM_SLOTS-1:0]   r_attacking;
    logic [1:0]             r_active_cnt;

    logic                   r_fc_meta;
    logic                   r_fc_sync;
    logic                   r_fc_prev;

    // ------------------------------------------------------------------------
    // Next-state wires
    // ------------------------------------------------------------------------
    state_t                 w_state_nxt;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [c_IDX_W-1:0]     w_rr_ptr_nxt;
    logic [c_IDX_W-1:0]     w_scan_idx_nxt;
    logic [c_IDX_W-1:0]     w_scan_cnt_nxt;
    logic [c_IDX_W-1:0]     w_sel_nxt;
    logic [NUM_SLOTS-1:0]   w_dive_req_nxt;
    logic [NUM_SLOTS-1:0]   w_attacking_nxt;
    logic [NUM_SLOTS-1:0]   w_set_mask;
    logic [1:0]             w_active_cnt_nxt;

    logic                   w_tick;
    logic                   w_abort;
    logic                   w_eligible;
    logic [c_POP_W-1:0]     w_attack_cnt;
    logic [NUM_SLOTS-1:0]   w_sel_onehot;
    logic [c_IDX_W-1:0]     w_scan_inc;
    logic [c_IDX_W-1:0]     w_rr_inc;

    // Bring the asynchronous frame strobe into the Clk domain and keep its previous value
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fc_meta <= 1'b0;
            r_fc_sync <= 1'b0;
            r_fc_prev <= 1'b0;
        end else begin
            r_fc_meta <= frame_clk;
            r_fc_sync <= r_fc_meta;
            r_fc_prev <= r_fc_sync;
        end
    end

    // One Clk-wide pulse per frame, on the synchronised rising edge
    assign w_tick = r_fc_sync & ~r_fc_prev;

    // Leaving the play state, or the round ending, wins over everything else
    assign w_abort = ~play | done;

    // Slot under the scan pointer can be launched only if alive and not already diving
    assign w_eligible = alive[r_scan_idx] & ~r_attacking[r_scan_idx];

    assign w_sel_onehot = c_ONE << r_sel;
    assign w_scan_inc   = (r_scan_idx == c_LAST_IDX) ? '0 : r_scan_idx + 1'b1;
    assign w_rr_inc     = (r_rr_ptr   == c_LAST_IDX) ? '0 : r_rr_ptr   + 1'b1;

    // Count ships currently diving; the cap check uses the live count so a
    // freshly cleared slot is seen on the very next cycle
    always_comb begin
        w_attack_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            w_attack_cnt = w_attack_cnt + c_POP_W'(r_attacking[i]);
        end
    end

    // Next-state, timer, scan and request decisions
    always_comb begin
        w_state_nxt    = r_state;
        w_timer_nxt    = r_timer;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_scan_idx_nxt = r_scan_idx;
        w_scan_cnt_nxt = r_scan_cnt;
        w_sel_nxt      = r_sel;
        w_dive_req_nxt = r_dive_req;
        w_set_mask     = '0;

        if (w_abort) begin
            w_state_nxt    = S_IDLE;
            w_dive_req_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_WAIT;
                    w_timer_nxt = c_RELOAD;
                end

                S_WAIT: begin
                    if ((r_timer == '0) && (w_attack_cnt < c_MAX_ACT)) begin
                        w_state_nxt    = S_SELECT;
                        w_scan_idx_nxt = w_rr_inc;
                        w_scan_cnt_nxt = '0;
                    end else if (w_tick && (r_timer != '0)) begin
                        w_timer_nxt = r_timer - 1'b1;
                    end
                end

                S_SELECT: begin
                    if (w_eligible) begin
                        w_sel_nxt   = r_scan_idx;
                        w_state_nxt = S_REQUEST;
                    end else if (r_scan_cnt == c_LAST_IDX) begin
                        // Whole ring scanned with nothing to launch: try again next interval
                        w_timer_nxt = c_RELOAD;
                        w_state_nxt = S_WAIT;
                    end else begin
                        w_scan_idx_nxt = w_scan_inc;
                        w_scan_cnt_nxt = r_scan_cnt + 1'b1;
                    end
                end

                S_REQUEST: begin
                    if (!alive[r_sel]) begin
                        // Ship was shot before it could leave formation: drop the request
                        w_dive_req_nxt = '0;
                        w_timer_nxt    = c_RELOAD;
                        w_state_nxt    = S_WAIT;
                    end else if ((r_dive_req != '0) && dive_ack[r_sel]) begin
                        w_dive_req_nxt = '0;
                        w_set_mask     = w_sel_onehot;
                        w_rr_ptr_nxt   = r_sel;
                        w_timer_nxt    = c_RELOAD;
                        w_state_nxt    = S_WAIT;
                    end else begin
                        w_dive_req_nxt = w_sel_onehot;
                    end
                end

                default: begin
                    w_state_nxt    = S_IDLE;
                    w_dive_req_nxt = '0;
                end
            endcase
        end
    end

    // Diver bookkeeping: returns and kills clear bits, an acknowledged launch sets one
    always_comb begin
        w_attacking_nxt  = r_attacking;
        w_active_cnt_nxt = (w_attack_cnt > c_POP_W'(3)) ? 2'd3 : w_attack_cnt[1:0];
        if (w_abort) begin
            w_attacking_nxt  = '0;
            w_active_cnt_nxt = 2'd0;
        end else if (r_state != S_IDLE) begin
            w_attacking_nxt = (r_attacking & ~(dive_done | ~alive)) | w_set_mask;
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_rr_ptr     <= c_LAST_IDX;
            r_scan_idx   <= '0;
            r_scan_cnt   <= '0;
            r_sel        <= '0;
            r_dive_req   <= '0;
            r_attacking  <= '0;
            r_active_cnt <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_timer      <= w_timer_nxt;
            r_rr_ptr     <= w_rr_ptr_nxt;
            r_scan_idx   <= w_scan_idx_nxt;
            r_scan_cnt   <= w_scan_cnt_nxt;
            r_sel        <= w_sel_nxt;
            r_dive_req   <= w_dive_req_nxt;
            r_attacking  <= w_attacking_nxt;
            r_active_cnt <= w_active_cnt_nxt;
        end
    end

    assign dive_req   = r_dive_req;
    assign attacking  = r_attacking;
    assign active_cnt = r_active_cnt;
    assign busy       = (r_state == S_SELECT) || (r_state == S_REQUEST);

endmodule
`default_nettype wire
